// File: rtl/mcp_send_arb_if.sv
// Channel-side and receive-side signals of the multi-cycle-path send arbiter.
// The master modport is the arbiter itself; the slave modport is its environment.
interface mcp_send_arb_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int GW = $clog2(NCH);

    logic [NCH-1:0]       ch_send;
    logic [NCH*WIDTH-1:0] ch_data;
    logic [NCH-1:0]       ch_ack;
    logic [WIDTH-1:0]     adata;
    logic                 a_en;
    logic                 aq2_ack;
    logic                 busy;
    logic [GW-1:0]        grant_id;
    logic                 err_clr;
    logic                 timeout_err;

    modport master (
        input  ch_send, ch_data, aq2_ack, err_clr,
        output ch_ack, adata, a_en, busy, grant_id, timeout_err
    );

    modport slave (
        output ch_send, ch_data, aq2_ack, err_clr,
        input  ch_ack, adata, a_en, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/mcp_send_arb.sv
// Round-robin arbiter feeding one toggle-enable multi-cycle-path transmitter.
// Define MCP_TIMEOUT_EN to add the sticky acknowledge-timeout flag.
module mcp_send_arb #(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    mcp_send_arb_if.master bus
);
    localparam int GW = $clog2(NCH);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t           state, state_d;
    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    pick;
    logic             found;
    logic             capture;
    logic [WIDTH-1:0] ch_word [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign ch_word[g] = bus.ch_data[g*WIDTH +: WIDTH];
    end

    // Search from the channel after the last grant; the first requester found wins.
    always_comb begin
        int            idx;
        logic [GW-1:0] cand;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found = 1'b0;
        pick  = last_grant;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NCH) idx = idx - NCH;
            cand = GW'(idx);
            if (!found && bus.ch_send[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    capture = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.aq2_ack == bus.a_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.adata    <= '0;
            bus.a_en     <= 1'b0;
            bus.ch_ack   <= '0;
            bus.grant_id <= '0;
            last_grant   <= GW'(NCH - 1);
        end else begin
            bus.ch_ack <= '0;
            if (capture) begin
                bus.adata    <= ch_word[pick];
                bus.a_en     <= ~bus.a_en;
                bus.ch_ack   <= NCH'(1) << pick;
                bus.grant_id <= pick;
                last_grant   <= pick;
            end
        end
    end

    assign bus.busy = (state == WAIT_ACK);

`ifdef MCP_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    // Fires once, on the edge the saturating count reaches TIMEOUT.
    assign tmo_hit = (state == WAIT_ACK) && (tmo_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt         <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            if (capture)
                tmo_cnt <= '0;
            else if (state == WAIT_ACK && tmo_cnt != 16'(TIMEOUT))
                tmo_cnt <= tmo_cnt + 16'd1;

            if (tmo_hit)          bus.timeout_err <= 1'b1;
            else if (bus.err_clr) bus.timeout_err <= 1'b0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    logic unused_err_clr;

    assign unused_err_clr  = bus.err_clr;
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_mcp_send_arb.sv
// Scoreboard bench for mcp_send_arb: stimulus queues expected grants, a monitor checks each ch_ack.
// A second NCH=3 instance covers the non-power-of-two wrap.
module tb_mcp_send_arb;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
`ifdef MCP_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       aen;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mcp_send_arb_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();
    mcp_send_arb_if #(.WIDTH(WIDTH), .NCH(3))   bus3 ();

    mcp_send_arb #(.WIDTH(WIDTH), .NCH(NCH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    mcp_send_arb #(.WIDTH(WIDTH), .NCH(3), .TIMEOUT(TMO)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    exp_t           exp_q[$];
    logic           exp_aen;
    int             n_pass  = 0;
    int             n_total = 0;
    int             n_acks  = 0;
    bit             auto_ack;
    logic [2:0]     ack_pipe;
    logic [NCH-1:0] prev_ack;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int ch, input logic [7:0] data);
        exp_aen = ~exp_aen;
        exp_q.push_back('{ch: ch, data: data, aen: exp_aen});
    endtask

    task automatic set_data(input int ch, input logic [7:0] v);
        bus.ch_data[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic wait_acks(input int target);
        int c = 0;
        while (n_acks < target && c < 100) begin
            tick();
            c++;
        end
        check("ack_count", n_acks, target);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (bus.busy && c < 100) begin
            tick();
            c++;
        end
        check("idle_reached", bus.busy, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_adata"},    bus.adata, 0);
        check({tag, "_a_en"},     bus.a_en, 0);
        check({tag, "_ch_ack"},   bus.ch_ack, 0);
        check({tag, "_busy"},     bus.busy, 0);
        check({tag, "_grant_id"}, bus.grant_id, 0);
        check({tag, "_tmo_err"},  bus.timeout_err, 0);
    endtask

    // Receive-side model: returns a_en as aq2_ack three cycles later.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            ack_pipe    = '0;
            bus.aq2_ack = 1'b0;
        end else begin
            ack_pipe = {ack_pipe[1:0], bus.a_en};
            if (auto_ack) bus.aq2_ack = ack_pipe[2];
        end
    end

    // Monitor: every ch_ack pulse is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        prev_ack = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_ack != '0) check("ack_single_cycle", bus.ch_ack, 0);
                if (bus.ch_ack != '0) begin
                    n_acks++;
                    check("ack_onehot", $countones(bus.ch_ack), 1);
                    if (exp_q.size() == 0) begin
                        check("ack_unexpected", bus.ch_ack, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_vec",   bus.ch_ack, 32'(1) << e.ch);
                        check("grant_id",  bus.grant_id, e.ch);
                        check("adata",     bus.adata, e.data);
                        check("a_en",      bus.a_en, e.aen);
                        check("ack_busy",  bus.busy, 1);
                    end
                end
                prev_ack = bus.ch_ack;
            end else begin
                prev_ack = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        bus.ch_send  = '0;
        bus.ch_data  = '0;
        bus.aq2_ack  = 1'b0;
        bus.err_clr  = 1'b0;
        bus3.ch_send = '0;
        bus3.ch_data = '0;
        bus3.aq2_ack = 1'b0;
        bus3.err_clr = 1'b0;
        auto_ack     = 1'b1;
        exp_aen      = 1'b0;
        rst_n        = 1'b0;
        repeat (2) tick();
        check_reset("por");
        rst_n = 1'b1;
        tick();

        // Single request from reset.
        set_data(0, 8'hA5);
        bus.ch_send = 4'b0001;
        push_exp(0, 8'hA5);
        wait_acks(1);
        bus.ch_send = '0;
        wait_idle();

        // Inputs changing during WAIT_ACK must not disturb adata/a_en.
        auto_ack = 1'b0;
        set_data(1, 8'h3C);
        bus.ch_send = 4'b0010;
        push_exp(1, 8'h3C);
        wait_acks(2);
        set_data(1, 8'hFF);
        set_data(2, 8'h5C);
        bus.ch_send = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold_adata", bus.adata, 8'h3C);
            check("hold_a_en",  bus.a_en, 0);
            check("hold_busy",  bus.busy, 1);
        end
        push_exp(2, 8'h5C);
        bus.aq2_ack = 1'b0;
        tick();
        check("idle_gap_busy",  bus.busy, 0);
        check("idle_gap_adata", bus.adata, 8'h3C);
        wait_acks(3);
        bus.ch_send = '0;
        auto_ack    = 1'b1;
        wait_idle();

        // Reset in the middle of WAIT_ACK, then pending requests resume.
        auto_ack = 1'b0;
        set_data(3, 8'h77);
        bus.ch_send = 4'b1000;
        push_exp(3, 8'h77);
        wait_acks(4);
        bus.ch_send = 4'b0110;
        set_data(1, 8'h21);
        set_data(2, 8'h32);
        tick();
        check("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        exp_aen  = 1'b0;
        auto_ack = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        push_exp(1, 8'h21);
        push_exp(2, 8'h32);
        wait_acks(5);
        bus.ch_send[1] = 1'b0;
        wait_acks(6);
        bus.ch_send = '0;
        wait_idle();

        // Round-robin over four held requests after reset: 0,1,2,3,0.
        rst_n = 1'b0;
        #1;
        exp_aen = 1'b0;
        tick();
        rst_n = 1'b1;
        set_data(0, 8'h11);
        set_data(1, 8'h22);
        set_data(2, 8'h33);
        set_data(3, 8'h44);
        bus.ch_send = 4'b1111;
        push_exp(0, 8'h11);
        push_exp(1, 8'h22);
        push_exp(2, 8'h33);
        push_exp(3, 8'h44);
        push_exp(0, 8'h11);
        wait_acks(11);
        bus.ch_send = '0;
        wait_idle();

        // aq2_ack toggling while IDLE is ignored.
        auto_ack    = 1'b0;
        bus.aq2_ack = 1'b0;
        repeat (3) tick();
        check("idle_toggle_busy",   bus.busy, 0);
        check("idle_toggle_a_en",   bus.a_en, 1);
        check("idle_toggle_ch_ack", bus.ch_ack, 0);
        bus.aq2_ack = 1'b1;
        tick();

        // Acknowledge withheld: timeout flag, clear, then late acknowledge.
        set_data(0, 8'h66);
        bus.ch_send = 4'b0001;
        push_exp(0, 8'h66);
        wait_acks(12);
        bus.ch_send = '0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("tmo_err",  bus.timeout_err, (TMO_EN && k >= 4) ? 1 : 0);
            check("tmo_busy", bus.busy, 1);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("tmo_clr", bus.timeout_err, 0);
        tick();
        check("tmo_stays_clr", bus.timeout_err, 0);
        check("tmo_still_busy", bus.busy, 1);
        bus.aq2_ack = 1'b0;
        tick();
        check("late_ack_idle", bus.busy, 0);

        // NCH=3: search after last grant 2 wraps to channel 0.
        bus3.ch_data = {8'h5A, 8'h00, 8'hC3};
        bus3.ch_send = 3'b101;
        tick();
        check("n3_ack_a",   bus3.ch_ack, 3'b001);
        check("n3_grant_a", bus3.grant_id, 0);
        check("n3_data_a",  bus3.adata, 8'hC3);
        check("n3_a_en_a",  bus3.a_en, 1);
        bus3.ch_send = 3'b100;
        bus3.aq2_ack = 1'b1;
        tick();
        check("n3_idle_a", bus3.busy, 0);
        tick();
        check("n3_ack_b",   bus3.ch_ack, 3'b100);
        check("n3_grant_b", bus3.grant_id, 2);
        check("n3_data_b",  bus3.adata, 8'h5A);
        bus3.ch_send = 3'b101;
        bus3.aq2_ack = 1'b0;
        tick();
        tick();
        check("n3_ack_c",   bus3.ch_ack, 3'b001);
        check("n3_grant_c", bus3.grant_id, 0);
        check("n3_a_en_c",  bus3.a_en, 1);
        bus3.ch_send = '0;
        bus3.aq2_ack = 1'b1;
        tick();
        tick();
        check("n3_idle_c", bus3.busy, 0);

        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
